// File: rtl/reg_select_decoder_if.sv
// reg_select_decoder_if: instruction input, pipeline controls and register-file select outputs
interface reg_select_decoder_if;
  logic [31:0] ibus;
  logic        stall;
  logic        flush;
  logic [31:0] Aselect;
  logic [31:0] Bselect;
  logic [31:0] Dselect;
  logic [31:0] Imm;
  logic        immflag;
  modport master (output ibus, stall, flush, input Aselect, Bselect, Dselect, Imm, immflag);
  modport slave  (input ibus, stall, flush, output Aselect, Bselect, Dselect, Imm, immflag);
endinterface

// File: rtl/reg_select_decoder.sv
// reg_select_decoder: IF/ID register with one-hot read selects and a delayed one-hot write select
module reg_select_decoder #(
  parameter int WB_DEPTH = 2
) (
  input logic clk,
  input logic reset,
  reg_select_decoder_if.slave bus
);
  logic [31:0] ir;
  logic [31:0] wb [WB_DEPTH];
  logic [4:0]  dest;
  logic [31:0] dsel_id;
  always_ff @(posedge clk or posedge reset)
    if (reset) ir <= '0;
    else if (bus.flush) ir <= '0;
    else if (!bus.stall) ir <= bus.ibus;
  // stage 0 takes a bubble (r0, which ignores writes) while stalled
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < WB_DEPTH; i++) wb[i] <= 32'h1;
    end else begin
      wb[0] <= bus.stall ? 32'h1 : dsel_id;
      for (int i = 1; i < WB_DEPTH; i++) wb[i] <= wb[i-1];
    end
  always_comb begin
    dest        = bus.immflag ? ir[20:16] : ir[15:11];
    dsel_id     = 32'h1 << dest;
    bus.immflag = |ir[31:26];
    bus.Aselect = 32'h1 << ir[25:21];
    bus.Bselect = 32'h1 << ir[20:16];
    bus.Imm     = {{16{ir[15]}}, ir[15:0]};
    bus.Dselect = wb[WB_DEPTH-1];
  end
endmodule

// File: tb/tb_reg_select_decoder.sv
// tb_reg_select_decoder: directed vectors with hand-computed selects, immediates and write-back timing
module tb_reg_select_decoder;
  logic clk = 0;
  logic reset;
  int errors = 0;
  int checks = 0;
  reg_select_decoder_if bus ();
  reg_select_decoder #(.WB_DEPTH(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct packed {
    logic [31:0] ibus;
    logic        stall;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic [31:0] imm;
    logic        flag;
  } vec_t;
  vec_t rows [20];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_A"}, bus.Aselect, 32'h1);
    check({tag, "_B"}, bus.Bselect, 32'h1);
    check({tag, "_D"}, bus.Dselect, 32'h1);
    check({tag, "_imm"}, bus.Imm, 32'h0);
    check({tag, "_flag"}, {31'b0, bus.immflag}, 32'h0);
  endtask
  localparam logic [31:0] I0 = 32'h014B4820;
  localparam logic [31:0] I1 = 32'h2065FFFF;
  localparam logic [31:0] I2 = 32'h00221820;
  localparam logic [31:0] I3 = 32'h20860010;
  localparam logic [31:0] I4 = 32'h00E86020;
  localparam logic [31:0] I5 = 32'h8FF18000;
  initial begin
    rows = '{
      '{I0, 1'b0, 1'b0, 32'h400,      32'h800,   32'h1,     32'h4820,     1'b0},
      '{I1, 1'b0, 1'b0, 32'h8,        32'h20,    32'h1,     32'hFFFFFFFF, 1'b1},
      '{I2, 1'b0, 1'b0, 32'h2,        32'h4,     32'h200,   32'h1820,     1'b0},
      '{I3, 1'b0, 1'b0, 32'h10,       32'h40,    32'h20,    32'h10,       1'b1},
      '{I4, 1'b0, 1'b0, 32'h80,       32'h100,   32'h8,     32'h6020,     1'b0},
      '{I5, 1'b0, 1'b0, 32'h80000000, 32'h20000, 32'h40,    32'hFFFF8000, 1'b1},
      '{I2, 1'b1, 1'b0, 32'h80000000, 32'h20000, 32'h1000,  32'hFFFF8000, 1'b1},
      '{I2, 1'b1, 1'b0, 32'h80000000, 32'h20000, 32'h1,     32'hFFFF8000, 1'b1},
      '{I0, 1'b0, 1'b0, 32'h400,      32'h800,   32'h1,     32'h4820,     1'b0},
      '{I1, 1'b0, 1'b0, 32'h8,        32'h20,    32'h20000, 32'hFFFFFFFF, 1'b1},
      '{I2, 1'b0, 1'b0, 32'h2,        32'h4,     32'h200,   32'h1820,     1'b0},
      '{I3, 1'b1, 1'b1, 32'h1,        32'h1,     32'h20,    32'h0,        1'b0},
      '{I4, 1'b0, 1'b0, 32'h80,       32'h100,   32'h1,     32'h6020,     1'b0},
      '{I0, 1'b0, 1'b0, 32'h400,      32'h800,   32'h1,     32'h4820,     1'b0},
      '{I0, 1'b0, 1'b0, 32'h400,      32'h800,   32'h1000,  32'h4820,     1'b0},
      '{I1, 1'b0, 1'b1, 32'h1,        32'h1,     32'h200,   32'h0,        1'b0},
      '{I1, 1'b0, 1'b0, 32'h8,        32'h20,    32'h200,   32'hFFFFFFFF, 1'b1},
      '{I3, 1'b0, 1'b0, 32'h10,       32'h40,    32'h1,     32'h10,       1'b1},
      '{I3, 1'b0, 1'b0, 32'h10,       32'h40,    32'h1,     32'h10,       1'b1},
      '{I3, 1'b0, 1'b0, 32'h10,       32'h40,    32'h40,    32'h10,       1'b1}
    };
    reset = 1;
    bus.ibus = I5;
    bus.stall = 0;
    bus.flush = 0;
    #3;
    check_idle("por");
    @(posedge clk);
    #1 reset = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 17) begin
        #2 reset = 1;
        #1 check_idle("midrst");
        #1 reset = 0;
      end
      bus.ibus = rows[i].ibus;
      bus.stall = rows[i].stall;
      bus.flush = rows[i].flush;
      @(posedge clk);
      #1;
      check($sformatf("r%0d_A", i), bus.Aselect, rows[i].a);
      check($sformatf("r%0d_B", i), bus.Bselect, rows[i].b);
      check($sformatf("r%0d_D", i), bus.Dselect, rows[i].d);
      check($sformatf("r%0d_imm", i), bus.Imm, rows[i].imm);
      check($sformatf("r%0d_flag", i), {31'b0, bus.immflag}, {31'b0, rows[i].flag});
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
